// File: rtl/reg_trace_streamer_if.sv
// Trace beat channel: one register value per beat, valid/ready handshake.
// Master drives the beat fields; slave returns out_ready.
interface reg_trace_streamer_if #(
  parameter int DATA_W = 32,
  parameter int SEQ_W  = 16,
  parameter int IDX_W  = 5
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic [SEQ_W-1:0]  out_seq;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_idx, out_seq, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_idx, out_seq, out_last,
    output out_ready
  );
endinterface

// File: rtl/reg_trace_streamer.sv
// Snapshots the register file on each executed instruction and streams it out one register per beat.
// First beat one cycle after capture, 1 beat/cycle under out_ready; beats hold while stalled, pulses during a stream are dropped.
module reg_trace_streamer #(
  parameter int NUM_REGS  = 32,
  parameter int DATA_W    = 32,
  parameter int SEQ_W     = 16,
  parameter int DIFF_MODE = 0,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       exec_pulse,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  reg_trace_streamer_if.master       trace,
  output logic                       busy,
  output logic [15:0]                drop_cnt
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   snap_q [NUM_REGS];
  logic [DATA_W-1:0]   snap_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [SEQ_W-1:0]    seq_ctr_q, seq_ctr_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;
  logic [SEQ_W-1:0]    out_seq_q, out_seq_d;
  logic                out_last_q, out_last_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  logic [DATA_W-1:0]   regs_in [NUM_REGS];
  logic [NUM_REGS-1:0] new_mask, new_rest, pend_rest;
  logic [IDX_W-1:0]    new_first, pend_first;
  logic                accept, cap_opp, capture;

  function automatic logic [IDX_W-1:0] first_set(input logic [NUM_REGS-1:0] m);
    first_set = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (m[i]) first_set = IDX_W'(i);
    end
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // snap_q doubles as the previous image for diff mode: both are replaced on every capture.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_in[i]  = regs_flat[DATA_W*i +: DATA_W];
      new_mask[i] = (DIFF_MODE != 0) ? (regs_in[i] != snap_q[i]) : 1'b1;
    end
    new_first  = first_set(new_mask);
    new_rest   = new_mask & ~onehot(new_first);
    pend_first = first_set(pend_q);
    pend_rest  = pend_q & ~onehot(pend_first);
  end

  always_comb begin
    accept  = out_valid_q & trace.out_ready;
    cap_opp = (state_q == IDLE) | (accept & out_last_q);
    capture = exec_pulse & cap_opp;

    state_d     = state_q;
    snap_d      = snap_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_seq_d   = out_seq_q;
    out_last_d  = out_last_q;
    seq_ctr_d   = seq_ctr_q + SEQ_W'(exec_pulse);
    drop_cnt_d  = drop_cnt_q;

    if (exec_pulse && !cap_opp && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    if (accept) begin
      if (out_last_q) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end else begin
        out_idx_d  = pend_first;
        out_data_d = snap_q[pend_first];
        out_last_d = (pend_rest == '0);
        pend_d     = pend_rest;
      end
    end

    // A capture on the last-beat accept overrides the return to IDLE, giving a bubble-free handover.
    if (capture) begin
      snap_d    = regs_in;
      out_seq_d = seq_ctr_q;
      if (new_mask != '0) begin
        state_d     = STREAM;
        out_valid_d = 1'b1;
        out_idx_d   = new_first;
        out_data_d  = regs_in[new_first];
        out_last_d  = (new_rest == '0);
        pend_d      = new_rest;
      end else begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        pend_d      = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < NUM_REGS; i++) snap_q[i] <= '0;
      pend_q      <= '0;
      seq_ctr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_seq_q   <= '0;
      out_last_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      pend_q      <= pend_d;
      seq_ctr_q   <= seq_ctr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_seq_q   <= out_seq_d;
      out_last_q  <= out_last_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign trace.out_valid = out_valid_q;
  assign trace.out_data  = out_data_q;
  assign trace.out_idx   = out_idx_q;
  assign trace.out_seq   = out_seq_q;
  assign trace.out_last  = out_last_q;
  assign busy            = (state_q == STREAM);
  assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_reg_trace_streamer.sv
// Directed bench: full-dump instance (DIFF_MODE=0) and diff instance (DIFF_MODE=1) sharing clock and reset.
module tb_reg_trace_streamer;
  localparam int NR = 32;
  localparam int DW = 32;
  localparam int SW = 16;
  localparam int IW = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pulse0, pulse1;
  logic [NR*DW-1:0] regs0, regs1;
  logic             busy0, busy1;
  logic [15:0]      drop0, drop1;

  always #5 clk = ~clk;

  reg_trace_streamer_if #(.DATA_W(DW), .SEQ_W(SW), .IDX_W(IW)) t0 ();
  reg_trace_streamer_if #(.DATA_W(DW), .SEQ_W(SW), .IDX_W(IW)) t1 ();

  reg_trace_streamer #(.NUM_REGS(NR), .DATA_W(DW), .SEQ_W(SW), .DIFF_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .exec_pulse(pulse0), .regs_flat(regs0),
    .trace(t0.master), .busy(busy0), .drop_cnt(drop0)
  );

  reg_trace_streamer #(.NUM_REGS(NR), .DATA_W(DW), .SEQ_W(SW), .DIFF_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .exec_pulse(pulse1), .regs_flat(regs1),
    .trace(t1.master), .busy(busy1), .drop_cnt(drop1)
  );

  typedef struct {
    logic        pulse;
    logic        vld;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } vec_t;

  vec_t tbl [34];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Advance until dut0 presents the given index, bounded.
  task automatic wait_idx0(input int target, input string name);
    int n = 0;
    while (!(t0.out_valid && int'(t0.out_idx) == target) && n < 100) begin
      tick();
      n++;
    end
    check(name, 64'(n < 100), 64'd1);
  endtask

  initial begin
    int exp_i;
    int cyc;

    rst_n = 1'b0; pulse0 = 1'b0; pulse1 = 1'b0;
    t0.out_ready = 1'b1; t1.out_ready = 1'b1;
    regs1 = '0;
    for (int i = 0; i < NR; i++) regs0[DW*i +: DW] = 32'(i * 3);

    tbl[0] = '{pulse: 1'b1, vld: 1'b0, idx: 5'd0, data: 32'd0, last: 1'b0};
    for (int k = 1; k <= 32; k++)
      tbl[k] = '{pulse: 1'b0, vld: 1'b1, idx: 5'(k - 1), data: 32'((k - 1) * 3), last: (k == 32)};
    tbl[33] = '{pulse: 1'b0, vld: 1'b0, idx: 5'd0, data: 32'd0, last: 1'b0};

    tick(); tick();
    rst_n = 1'b1;

    check("rst_valid0", 64'(t0.out_valid), 64'd0);
    check("rst_busy0",  64'(busy0), 64'd0);
    check("rst_data0",  64'(t0.out_data), 64'd0);
    check("rst_seq0",   64'(t0.out_seq), 64'd0);
    check("rst_drop0",  64'(drop0), 64'd0);
    check("rst_valid1", 64'(t1.out_valid), 64'd0);

    // Diff mode on the second instance.
    regs1[DW*3 +: DW] = 32'd5;
    regs1[DW*7 +: DW] = 32'd9;
    pulse1 = 1'b1; tick(); pulse1 = 1'b0;
    check("d1_valid", 64'(t1.out_valid), 64'd1);
    check("d1_idx",   64'(t1.out_idx), 64'd3);
    check("d1_data",  64'(t1.out_data), 64'd5);
    check("d1_last",  64'(t1.out_last), 64'd0);
    tick();
    check("d2_idx",   64'(t1.out_idx), 64'd7);
    check("d2_data",  64'(t1.out_data), 64'd9);
    check("d2_last",  64'(t1.out_last), 64'd1);
    tick();
    check("d_end_valid", 64'(t1.out_valid), 64'd0);
    pulse1 = 1'b1; tick(); pulse1 = 1'b0;
    check("d_same_valid", 64'(t1.out_valid), 64'd0);
    check("d_same_busy",  64'(busy1), 64'd0);
    tick();
    check("d_same_busy2", 64'(busy1), 64'd0);
    check("d_same_drop",  64'(drop1), 64'd0);
    regs1[DW*7 +: DW] = 32'd10;
    pulse1 = 1'b1; tick(); pulse1 = 1'b0;
    check("d3_valid", 64'(t1.out_valid), 64'd1);
    check("d3_idx",   64'(t1.out_idx), 64'd7);
    check("d3_data",  64'(t1.out_data), 64'd10);
    check("d3_last",  64'(t1.out_last), 64'd1);
    check("d3_seq",   64'(t1.out_seq), 64'd2);
    tick();
    check("d3_end_valid", 64'(t1.out_valid), 64'd0);

    // Full dump, ready held high.
    for (int k = 0; k < 34; k++) begin
      check($sformatf("t1_valid[%0d]", k), 64'(t0.out_valid), 64'(tbl[k].vld));
      check($sformatf("t1_busy[%0d]", k),  64'(busy0), 64'(tbl[k].vld));
      if (tbl[k].vld) begin
        check($sformatf("t1_idx[%0d]", k),  64'(t0.out_idx), 64'(tbl[k].idx));
        check($sformatf("t1_data[%0d]", k), 64'(t0.out_data), 64'(tbl[k].data));
        check($sformatf("t1_last[%0d]", k), 64'(t0.out_last), 64'(tbl[k].last));
        check($sformatf("t1_seq[%0d]", k),  64'(t0.out_seq), 64'd0);
      end
      pulse0 = tbl[k].pulse;
      tick();
    end

    // Full dump with ready toggling; stalled beats must hold.
    pulse0 = 1'b1; tick(); pulse0 = 1'b0;
    exp_i = 0;
    cyc = 1;
    while (exp_i < 32 && cyc < 80) begin
      t0.out_ready = (cyc % 2 == 0);
      check("t2_valid", 64'(t0.out_valid), 64'd1);
      check("t2_idx",   64'(t0.out_idx), 64'(exp_i));
      check("t2_data",  64'(t0.out_data), 64'(exp_i * 3));
      check("t2_last",  64'(t0.out_last), 64'(exp_i == 31));
      check("t2_seq",   64'(t0.out_seq), 64'd1);
      if (t0.out_ready) exp_i++;
      tick();
      cyc++;
    end
    check("t2_count", 64'(exp_i), 64'd32);
    check("t2_within_64", 64'(cyc <= 65), 64'd1);
    check("t2_end_valid", 64'(t0.out_valid), 64'd0);
    t0.out_ready = 1'b1;

    // Drops and back-to-back handover after a fresh reset.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    pulse0 = 1'b1; tick(); pulse0 = 1'b0;
    wait_idx0(10, "t3_reach10");
    pulse0 = 1'b1; tick(); pulse0 = 1'b0;
    check("t3_drop1",  64'(drop0), 64'd1);
    check("t3_cont",   64'(t0.out_idx), 64'd11);
    wait_idx0(31, "t3_reach31a");
    tick();
    check("t3_idle", 64'(t0.out_valid), 64'd0);
    pulse0 = 1'b1; tick(); pulse0 = 1'b0;
    check("t3_seq2",  64'(t0.out_seq), 64'd2);
    check("t3_idx0",  64'(t0.out_idx), 64'd0);
    wait_idx0(31, "t3_reach31b");
    check("t3_last", 64'(t0.out_last), 64'd1);
    pulse0 = 1'b1; tick(); pulse0 = 1'b0;
    check("t3_b2b_valid", 64'(t0.out_valid), 64'd1);
    check("t3_b2b_idx",   64'(t0.out_idx), 64'd0);
    check("t3_b2b_seq",   64'(t0.out_seq), 64'd3);
    check("t3_b2b_drop",  64'(drop0), 64'd1);

    // Reset mid-stream at beat 5.
    wait_idx0(5, "t5_reach5");
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("t5_valid", 64'(t0.out_valid), 64'd0);
    check("t5_busy",  64'(busy0), 64'd0);
    check("t5_drop",  64'(drop0), 64'd0);
    check("t5_idx",   64'(t0.out_idx), 64'd0);
    check("t5_seq",   64'(t0.out_seq), 64'd0);
    check("t5_last",  64'(t0.out_last), 64'd0);
    pulse0 = 1'b1; tick(); pulse0 = 1'b0;
    check("t5_restart_valid", 64'(t0.out_valid), 64'd1);
    check("t5_restart_idx",   64'(t0.out_idx), 64'd0);
    check("t5_restart_seq",   64'(t0.out_seq), 64'd0);

    // Drop counter saturation during a stalled stream.
    t0.out_ready = 1'b0;
    pulse0 = 1'b1;
    repeat (65534) tick();
    check("t6_drop_65534", 64'(drop0), 64'd65534);
    tick();
    check("t6_drop_65535", 64'(drop0), 64'd65535);
    repeat (70000 - 65535) tick();
    pulse0 = 1'b0;
    check("t6_drop_sat", 64'(drop0), 64'd65535);
    check("t6_hold_idx", 64'(t0.out_idx), 64'd0);
    check("t6_hold_vld", 64'(t0.out_valid), 64'd1);
    t0.out_ready = 1'b1;
    wait_idx0(31, "t6_drain");
    tick();
    check("t6_end_valid", 64'(t0.out_valid), 64'd0);
    check("t6_end_drop",  64'(drop0), 64'd65535);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
